// File: rtl/reg_file32.sv
// reg_file32: 2**ADDR_W x DATA_W register file with two combinational read ports,
// one synchronous write port, hard-wired zero at address 0 and optional write forwarding.
module reg_file32 #(
   parameter int              DATA_W    = 32,
   parameter int              ADDR_W    = 5,
   parameter bit              BYPASS    = 1'b1,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rega,
   output logic [DATA_W-1:0] regb
);
   localparam int N = 2 ** ADDR_W;
   logic [DATA_W-1:0] regs [N];
   logic              wr_hit;
   // entry 0 is held at zero and never written; reads of address 0 are also forced to zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs[0] <= '0;
         for (int i = 1; i < N; i++) regs[i] <= RESET_VAL;
      end else if (we && wr_addr != '0) begin
         regs[wr_addr] <= wr_data;
      end
   end
   // forwarding is suppressed during reset, since no write will land
   always_comb begin
      wr_hit = BYPASS && rst_n && we && wr_addr != '0;
      rega = (rs_addr == '0) ? '0 : (wr_hit && wr_addr == rs_addr) ? wr_data : regs[rs_addr];
      regb = (rt_addr == '0) ? '0 : (wr_hit && wr_addr == rt_addr) ? wr_data : regs[rt_addr];
   end
endmodule
